// File: rtl/ctrl_pkg.sv
// Shared opcode, state and mux-select encodings for the multi-cycle controller.
// Pure definitions; no latency and no flow control of their own.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_OUT     = 4'h6;
    localparam logic [3:0] OP_IN      = 4'h7;
    localparam logic [3:0] OP_BR      = 4'h9;
    localparam logic [3:0] OP_BRC     = 4'hA;
    localparam logic [3:0] OP_BRSUB   = 4'hB;
    localparam logic [3:0] OP_RET     = 4'hC;
    localparam logic [3:0] OP_LOAD    = 4'hD;
    localparam logic [3:0] OP_STORE   = 4'hE;
    localparam logic [3:0] OP_LOADIMM = 4'hF;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_LR  = 2'b01;
    localparam logic [1:0] PC_EA  = 2'b10;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_INPORT = 2'b01;
    localparam logic [1:0] WB_IMM    = 2'b10;
    localparam logic [1:0] WB_MEM    = 2'b11;

    localparam logic BR_Z = 1'b0;
    localparam logic BR_N = 1'b1;

    // ALU-class opcodes drive alu_op; STORE uses the ALU for address generation.
    function automatic logic is_alu(input logic [3:0] op);
        return ((op >= 4'h1) && (op <= 4'h8)) || (op == OP_STORE);
    endfunction

    // Opcodes whose ALU result is written back to the register file.
    function automatic logic is_alu_wb(input logic [3:0] op);
        return ((op >= 4'h1) && (op <= 4'h5)) || (op == 4'h8);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op >= OP_BR) && (op <= OP_RET);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unacknowledged memory-request cycles; expired is combinational
// and marks the cycle whose missing ack would push the count to TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = inc && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC[/MEM[/WB]], 3/4/5 cycles at zero wait.
// Stalls in FETCH/MEM until mem_ack; a request unanswered for TIMEOUT cycles locks in FAULT.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int INST_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] inst,
    input  logic              flag_z,
    input  logic              flag_n,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              ir_en,
    output logic              pc_en,
    output logic [3:0]        alu_op,
    output logic [1:0]        pc_sel,
    output logic [1:0]        wb_sel,
    output logic              wb_demux_sel,
    output logic              br_sel,
    output logic              wt_sel,
    output logic              lr_en,
    output logic              reg_en,
    output logic              mem_en,
    output logic [2:0]        state,
    output logic              fault
);

    state_e      state_q, state_d;
    logic [3:0]  opcode_q;
    logic        brx_q;
    logic        expired;
    logic        inst_unused;

    assign inst_unused = ^inst[INST_W-6:0];
    assign mem_req     = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign state       = state_q;

    // Counter is held at zero outside FETCH/MEM, so every request starts fresh.
    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!mem_req || mem_ack),
        .inc     (mem_req && !mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        alu_op       = 4'h0;
        pc_sel       = PC_INC;
        wb_sel       = WB_ALU;
        wb_demux_sel = 1'b0;
        br_sel       = BR_Z;
        wt_sel       = 1'b0;
        lr_en        = 1'b0;
        reg_en       = 1'b0;
        mem_en       = 1'b0;
        fault        = 1'b0;

        case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_en   = 1'b1;
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_alu(opcode_q)) alu_op = opcode_q;
                if (is_alu_wb(opcode_q)) reg_en = 1'b1;
                case (opcode_q)
                    OP_OUT: begin
                        reg_en       = 1'b1;
                        wb_demux_sel = 1'b1;
                    end
                    OP_IN: begin
                        reg_en = 1'b1;
                        wb_sel = WB_INPORT;
                    end
                    OP_LOADIMM: begin
                        reg_en = 1'b1;
                        wb_sel = WB_IMM;
                    end
                    OP_BR:  pc_sel = PC_EA;
                    OP_BRC: begin
                        br_sel = brx_q;
                        pc_sel = (brx_q ? flag_n : flag_z) ? PC_EA : PC_INC;
                    end
                    OP_BRSUB: begin
                        pc_sel = PC_EA;
                        lr_en  = 1'b1;
                    end
                    OP_RET: pc_sel = PC_LR;
                    default: ;
                endcase
                if ((opcode_q == OP_LOAD) || (opcode_q == OP_STORE)) begin
                    state_d = ST_MEM;
                end else begin
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (is_alu(opcode_q)) alu_op = opcode_q;
                if (opcode_q == OP_STORE) begin
                    wt_sel = 1'b1;
                    mem_en = 1'b1;
                end
                if (mem_ack) begin
                    if (opcode_q == OP_STORE) begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_en  = 1'b1;
                wb_sel  = WB_MEM;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FAULT:  fault = 1'b1;
            default:   state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RST;
            opcode_q <= 4'h0;
            brx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_FETCH) && mem_ack) begin
                opcode_q <= inst[INST_W-1 -: 4];
                brx_q    <= inst[INST_W-5];
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: stimulus pushes expected per-cycle outputs,
// a monitor pops and compares them on the falling edge.
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] st;
        logic       flt;
        logic       req;
        logic       ir;
        logic       pce;
        logic [3:0] aop;
        logic [1:0] pcs;
        logic [1:0] wbs;
        logic       wbd;
        logic       brs;
        logic       wt;
        logic       lr;
        logic       rg;
        logic       men;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst;
    logic        flag_z, flag_n, mem_ack;
    logic        mem_req, ir_en, pc_en;
    logic [3:0]  alu_op;
    logic [1:0]  pc_sel, wb_sel;
    logic        wb_demux_sel, br_sel, wt_sel, lr_en, reg_en, mem_en;
    logic [2:0]  state;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    out_t  exp_q[$];
    string name_q[$];

    multicycle_controller #(.INST_W(16), .TIMEOUT(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .ir_en        (ir_en),
        .pc_en        (pc_en),
        .alu_op       (alu_op),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .wb_demux_sel (wb_demux_sel),
        .br_sel       (br_sel),
        .wt_sel       (wt_sel),
        .lr_en        (lr_en),
        .reg_en       (reg_en),
        .mem_en       (mem_en),
        .state        (state),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [2:0] st, input logic req = 1'b0, input logic ir = 1'b0,
                                input logic pce = 1'b0, input logic [3:0] aop = 4'h0,
                                input logic [1:0] pcs = 2'b00, input logic [1:0] wbs = 2'b00,
                                input logic wbd = 1'b0, input logic brs = 1'b0, input logic wt = 1'b0,
                                input logic lr = 1'b0, input logic rg = 1'b0, input logic men = 1'b0,
                                input logic flt = 1'b0);
        out_t o;
        o.st = st;   o.flt = flt; o.req = req; o.ir = ir;   o.pce = pce; o.aop = aop;
        o.pcs = pcs; o.wbs = wbs; o.wbd = wbd; o.brs = brs; o.wt = wt;   o.lr = lr;
        o.rg = rg;   o.men = men;
        return o;
    endfunction

    task automatic cyc(input logic rn, input logic [15:0] i, input logic a, input logic z,
                       input logic n, input out_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n   = rn;
        inst    = i;
        mem_ack = a;
        flag_z  = z;
        flag_n  = n;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares every cycle that has an expectation queued.
    initial begin
        out_t  e, act;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {state, fault, mem_req, ir_en, pc_en, alu_op, pc_sel, wb_sel,
                       wb_demux_sel, br_sel, wt_sel, lr_en, reg_en, mem_en};
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    logic [15:0] s_inst [7];
    out_t        s_exp  [7];

    initial begin
        rst_n = 1'b0; inst = '0; mem_ack = 1'b0; flag_z = 1'b0; flag_n = 1'b0;

        s_inst[0] = 16'h6ABC; s_exp[0] = mk(3'd3, .pce(1), .aop(4'h6), .rg(1), .wbd(1));
        s_inst[1] = 16'h7000; s_exp[1] = mk(3'd3, .pce(1), .aop(4'h7), .rg(1), .wbs(2'b01));
        s_inst[2] = 16'hC000; s_exp[2] = mk(3'd3, .pce(1), .pcs(2'b01));
        s_inst[3] = 16'hB000; s_exp[3] = mk(3'd3, .pce(1), .pcs(2'b10), .lr(1));
        s_inst[4] = 16'h0000; s_exp[4] = mk(3'd3, .pce(1));
        s_inst[5] = 16'h9000; s_exp[5] = mk(3'd3, .pce(1), .pcs(2'b10));
        s_inst[6] = 16'h8123; s_exp[6] = mk(3'd3, .pce(1), .aop(4'h8), .rg(1));

        // Reset and release: exactly one RST cycle, then FETCH.
        cyc(0, 16'h0000, 0, 0, 0, mk(3'd0), "reset");
        cyc(1, 16'h0000, 0, 0, 0, mk(3'd0), "rst_cycle");

        // ADD, zero wait; ack in DECODE must be ignored.
        cyc(1, 16'h1234, 1, 0, 0, mk(3'd1, .req(1), .ir(1)), "add_fetch");
        cyc(1, 16'h1234, 1, 0, 0, mk(3'd2), "add_decode");
        cyc(1, 16'h1234, 0, 0, 0, mk(3'd3, .pce(1), .aop(4'h1), .rg(1)), "add_exec");

        // BR.cond on N, taken; flags outside EXEC are irrelevant.
        cyc(1, 16'hA812, 1, 0, 0, mk(3'd1, .req(1), .ir(1)), "brc_t_fetch");
        cyc(1, 16'hA812, 0, 0, 0, mk(3'd2), "brc_t_decode");
        cyc(1, 16'hA812, 0, 0, 1, mk(3'd3, .pce(1), .pcs(2'b10), .brs(1)), "brc_taken");
        cyc(1, 16'hA812, 1, 0, 0, mk(3'd1, .req(1), .ir(1)), "brc_nt_fetch");
        cyc(1, 16'hA812, 0, 0, 1, mk(3'd2), "brc_nt_decode");
        cyc(1, 16'hA812, 0, 1, 0, mk(3'd3, .pce(1), .pcs(2'b00), .brs(1)), "brc_not_taken");

        // STORE with one wait state.
        cyc(1, 16'hE000, 1, 0, 0, mk(3'd1, .req(1), .ir(1)), "st_fetch");
        cyc(1, 16'hE000, 0, 0, 0, mk(3'd2), "st_decode");
        cyc(1, 16'hE000, 0, 0, 0, mk(3'd3, .aop(4'hE)), "st_exec");
        cyc(1, 16'hE000, 0, 0, 0, mk(3'd4, .req(1), .aop(4'hE), .wt(1), .men(1)), "st_mem_wait");
        cyc(1, 16'hE000, 1, 0, 0, mk(3'd4, .req(1), .aop(4'hE), .wt(1), .men(1), .pce(1)), "st_mem_ack");

        // LOAD with two wait states: ack lands on the TIMEOUT cycle; 7 cycles total.
        cyc(1, 16'hD000, 1, 0, 0, mk(3'd1, .req(1), .ir(1)), "ld_fetch");
        cyc(1, 16'hD000, 0, 0, 0, mk(3'd2), "ld_decode");
        cyc(1, 16'hD000, 0, 0, 0, mk(3'd3), "ld_exec");
        cyc(1, 16'hD000, 0, 0, 0, mk(3'd4, .req(1)), "ld_wait1");
        cyc(1, 16'hD000, 0, 0, 0, mk(3'd4, .req(1)), "ld_wait2");
        cyc(1, 16'hD000, 1, 0, 0, mk(3'd4, .req(1)), "ld_ack_at_limit");
        cyc(1, 16'hD000, 0, 0, 0, mk(3'd5, .rg(1), .wbs(2'b11), .pce(1)), "ld_wb");

        // LOADIMM with fetch acked on the TIMEOUT cycle.
        cyc(1, 16'hF000, 0, 0, 0, mk(3'd1, .req(1)), "li_fwait1");
        cyc(1, 16'hF000, 0, 0, 0, mk(3'd1, .req(1)), "li_fwait2");
        cyc(1, 16'hF000, 1, 0, 0, mk(3'd1, .req(1), .ir(1)), "li_fetch_ack");
        cyc(1, 16'hF000, 0, 0, 0, mk(3'd2), "li_decode");
        cyc(1, 16'hF000, 0, 0, 0, mk(3'd3, .pce(1), .rg(1), .wbs(2'b10)), "li_exec");

        for (int k = 0; k < 7; k++) begin
            cyc(1, s_inst[k], 1, 0, 0, mk(3'd1, .req(1), .ir(1)), $sformatf("fetch_%h", s_inst[k]));
            cyc(1, s_inst[k], 0, 0, 0, mk(3'd2), $sformatf("decode_%h", s_inst[k]));
            cyc(1, s_inst[k], 0, 0, 0, s_exp[k], $sformatf("exec_%h", s_inst[k]));
        end

        // Asynchronous reset in the middle of a STORE wait.
        cyc(1, 16'hE000, 1, 0, 0, mk(3'd1, .req(1), .ir(1)), "st2_fetch");
        cyc(1, 16'hE000, 0, 0, 0, mk(3'd2), "st2_decode");
        cyc(1, 16'hE000, 0, 0, 0, mk(3'd3, .aop(4'hE)), "st2_exec");
        cyc(1, 16'hE000, 0, 0, 0, mk(3'd4, .req(1), .aop(4'hE), .wt(1), .men(1)), "st2_mem_wait");
        cyc(0, 16'hE000, 0, 0, 0, mk(3'd0), "rst_mid_mem");
        cyc(1, 16'hE000, 0, 0, 0, mk(3'd0), "rst_mid_release");

        // Timeout: no ack for 3 fetch cycles, then FAULT stays despite acks.
        cyc(1, 16'h0000, 0, 0, 0, mk(3'd1, .req(1)), "to_fetch1");
        cyc(1, 16'h0000, 0, 0, 0, mk(3'd1, .req(1)), "to_fetch2");
        cyc(1, 16'h0000, 0, 0, 0, mk(3'd1, .req(1)), "to_fetch3");
        cyc(1, 16'h1000, 1, 0, 0, mk(3'd6, .flt(1)), "fault_set");
        cyc(1, 16'h1000, 1, 1, 1, mk(3'd6, .flt(1)), "fault_sticky");
        cyc(0, 16'h0000, 0, 0, 0, mk(3'd0), "fault_reset");
        cyc(1, 16'h0000, 0, 0, 0, mk(3'd0), "fault_rst_cycle");
        cyc(1, 16'h0000, 0, 0, 0, mk(3'd1, .req(1)), "fetch_after_fault");

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle 16-bit control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with a memory that may take wait states. It samples branch flags at a defined cycle and flags a sticky fault if memory stops responding. It sits between the instruction register, register file, ALU, PC/LR logic and the memory port.

## Interface
Parameters:
- INST_W, 16, instruction width; opcode = inst[INST_W-1:INST_W-4], brx = inst[INST_W-5]; legal range ≥ 8
- TIMEOUT, 15, max consecutive cycles a memory request may wait for ack; legal range 1..255

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst  in  INST_W  instruction word from memory (valid with mem_ack in FETCH)
- flag_z, flag_n  in  1 each  ALU status flags
- mem_ack  in  1  memory completion for the current request
- mem_req  out  1  memory request (fetch, load or store)
- ir_en  out  1  load instruction register (one-cycle pulse)
- pc_en  out  1  update PC (one-cycle pulse, last cycle of instruction)
- alu_op  out  4  ALU operation
- pc_sel, wb_sel  out  2 each  PC source / writeback source
- wb_demux_sel, br_sel, wt_sel, lr_en, reg_en, mem_en  out  1 each  existing datapath controls
- state  out  3  current state, for debug
- fault  out  1  sticky memory-timeout fault

## Operation
- Encodings:
  - pc_sel: 00 PC+2, 01 LR, 10 ea
  - wb_sel: 00 ALU result, 01 in.port, 10 imm, 11 M[ea]
  - wb_demux_sel: 0 register, 1 out.port
  - br_sel: 0 Z, 1 N
- States: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. Outputs are decoded from the state and the latched opcode/brx.
- RST → FETCH unconditionally.
- FETCH: mem_req=1. On mem_ack: ir_en=1, opcode and brx are latched, go to DECODE.
- DECODE: all enables 0. Go to EXEC.
- EXEC:
  - ALU ops 0001–0101 and 1000: reg_en=1, wb_sel=00.
  - OUT 0110: reg_en=1, wb_demux_sel=1.
  - IN 0111: reg_en=1, wb_sel=01.
  - LOADIMM 1111: reg_en=1, wb_sel=10.
  - NOP 0000: no enables.
  - BR 1001: pc_sel=10.
  - BR.cond 1010: br_sel=brx; pc_sel=10 if the selected flag is 1, else 00.
  - BR.SUB 1011: pc_sel=10, lr_en=1.
  - RET 1100: pc_sel=01.
  - All of the above: pc_en=1, then go to FETCH.
  - LOAD 1101 and STORE 1110: no enables, go to MEM.
- MEM: mem_req=1.
  - STORE: wt_sel=1 and mem_en=1 while in MEM. On ack: pc_en=1, go to FETCH.
  - LOAD: on ack, go to WB.
- WB (LOAD only): reg_en=1, wb_sel=11, pc_en=1, go to FETCH.
- alu_op carries the opcode for ALU-class instructions (0001–1000, 1110) and 0000 otherwise.
- Timeout: the wait counter clears on entry to FETCH/MEM and on ack, and increments each cycle mem_req=1 without ack. When the counter reaches TIMEOUT with no ack, go to FAULT.
- FAULT: fault=1, all other outputs 0. Left only by reset.

## Timing
- mem_ack is sampled on the rising edge while mem_req=1. Ack in the first request cycle is legal (zero wait). Ack while mem_req=0 is ignored.
- Latency with zero-wait memory: ALU/branch/NOP = 3 cycles; STORE = 4; LOAD = 5. Each memory wait cycle adds 1.
- Branch flags are sampled combinationally during EXEC only. Flag changes in any other state have no effect.
- Ack on exactly cycle TIMEOUT is accepted; a timeout is declared only if there is no ack by then.
- rst_n low at any time, including mid-MEM: state=RST immediately, all outputs 0, fault=0, counter=0.
- At reset release: one RST cycle, then mem_req=1.

## Structure
- ctrl_pkg holds:
  - opcode localparams
  - state encoding
  - pc_sel/wb_sel/br_sel encodings
  - opcode-class helper functions (is_alu, is_branch)
- One sub-module, mem_wait_timer: counter with clear, inc, and a `expired` output; width clog2(TIMEOUT+1).
- The controller instantiates mem_wait_timer; the FSM and output decode stay in the top module.

## Test plan
- Reset mid-MEM: assert rst_n=0 during a STORE wait → all outputs 0 immediately; after release, one RST cycle then FETCH with mem_req=1.
- ADD 0x1xxx, zero-wait ack → ir_en in cycle 1; in cycle 3 reg_en=1, pc_en=1, alu_op=0001; back in FETCH at cycle 4.
- BR.cond 0xA8xx (brx=1) with flag_n=1, flag_z=0 → EXEC shows br_sel=1, pc_sel=10. Repeat with flag_n=0 → pc_sel=00.
- LOAD 0xDxxx with 2 wait states in MEM → WB asserts reg_en=1, wb_sel=11, pc_en=1; total 7 cycles.
- STORE 0xExxx → MEM holds wt_sel=1, mem_en=1, alu_op=1110 until ack; pc_en pulses in the ack cycle.
- TIMEOUT=3, no ack in FETCH → state=FAULT after 3 cycles, fault=1 sticky despite later acks; cleared only by reset.
